// File: rtl/shift_add_mul_ctrl.sv
// Shift-and-add unsigned multiplier sequencer driving an external WIDTH-bit adder.
// Optional abort input enabled by defining SHIFT_ADD_MUL_ABORT_EN.
module shift_add_mul_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef SHIFT_ADD_MUL_ABORT_EN
  input  logic               abort,
`endif
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_c0,
  input  logic [WIDTH-1:0]   add_f,
  input  logic               add_c8
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_m;
  logic               r_cy;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic               w_abort;
  logic               w_carry;
  logic               w_last;
  logic [2*WIDTH:0]   w_shift;

`ifdef SHIFT_ADD_MUL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign add_a  = r_acc;
  assign add_b  = (r_state == RUN && r_q[0]) ? r_m : '0;
  assign add_c0 = 1'b0;

  // cy is always 0 entering a step, so OR-ing it in keeps {cy,acc}+m exact.
  assign w_carry = add_c8 | r_cy;
  assign w_shift = {w_carry, add_f, r_q} >> 1;
  assign w_last  = (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_cy      <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_cy    <= 1'b0;
            r_q     <= mplier;
            r_m     <= mcand;
            r_cnt   <= CW'(WIDTH);
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_abort) begin
            r_state <= IDLE;
          end else begin
            r_cy  <= w_shift[2*WIDTH];
            r_acc <= w_shift[2*WIDTH-1:WIDTH];
            r_q   <= w_shift[WIDTH-1:0];
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
              // Capture the final shifted value so product is valid during DONE.
              r_product <= w_shift[2*WIDTH-1:0];
              r_state   <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = (r_state == RUN) || (r_state == DONE);
  assign done    = (r_state == DONE);
  assign product = r_product;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Directed, table-driven bench for shift_add_mul_ctrl with a behavioural adder model.
module tb_shift_add_mul_ctrl;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_c0;
  logic [W-1:0]   add_f;
  logic           add_c8;
`ifdef SHIFT_ADD_MUL_ABORT_EN
  logic           abort;
`endif

  shift_add_mul_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
`ifdef SHIFT_ADD_MUL_ABORT_EN
    .abort  (abort),
`endif
    .mcand  (mcand),
    .mplier (mplier),
    .busy   (busy),
    .done   (done),
    .product(product),
    .add_a  (add_a),
    .add_b  (add_b),
    .add_c0 (add_c0),
    .add_f  (add_f),
    .add_c8 (add_c8)
  );

  // External adder
  assign {add_c8, add_f} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_c0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t           vecs [12];
  int             n_vec  = 0;
  int             n_miss = 0;
  logic [2*W-1:0] last_prod;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    @(negedge clk);
    start  = 1'b0;
    mcand  = W'($urandom);
    mplier = W'($urandom);
    for (int c = 1; c <= 10; c++) begin
      if (c <= W) begin
        check($sformatf("busy %h*%h c%0d", a, b, c), 32'(busy), 32'd1);
        check($sformatf("done %h*%h c%0d", a, b, c), 32'(done), 32'd0);
        check($sformatf("hold %h*%h c%0d", a, b, c), 32'(product), 32'(last_prod));
        check($sformatf("add_b %h*%h c%0d", a, b, c), 32'(add_b), b[c-1] ? 32'(a) : 32'd0);
      end else if (c == W + 1) begin
        check($sformatf("busy %h*%h done", a, b), 32'(busy), 32'd1);
        check($sformatf("done %h*%h pulse", a, b), 32'(done), 32'd1);
        check($sformatf("product %h*%h", a, b), 32'(product), 32'(exp));
        check($sformatf("add_b %h*%h done", a, b), 32'(add_b), 32'd0);
      end else begin
        check($sformatf("busy %h*%h idle", a, b), 32'(busy), 32'd0);
        check($sformatf("done %h*%h idle", a, b), 32'(done), 32'd0);
        check($sformatf("product %h*%h held", a, b), 32'(product), 32'(exp));
      end
      check($sformatf("add_c0 c%0d", c), 32'(add_c0), 32'd0);
      @(negedge clk);
    end
    last_prod = exp;
  endtask

  initial begin
    int n_done;
    int first_done;
    int last_done;

    vecs[0]  = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[1]  = '{8'h80, 8'h02, 16'h0100};
    vecs[2]  = '{8'h00, 8'hA5, 16'h0000};
    vecs[3]  = '{8'h0F, 8'h0F, 16'h00E1};
    vecs[4]  = '{8'h02, 8'h03, 16'h0006};
    vecs[5]  = '{8'h12, 8'h34, 16'h03A8};
    vecs[6]  = '{8'h03, 8'h05, 16'h000F};
    vecs[7]  = '{8'h01, 8'hFF, 16'h00FF};
    vecs[8]  = '{8'hFF, 8'h01, 16'h00FF};
    vecs[9]  = '{8'hAA, 8'h55, 16'h3872};
    vecs[10] = '{8'h80, 8'h80, 16'h4000};
    vecs[11] = '{8'h7F, 8'h81, 16'h3FFF};

    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
`ifdef SHIFT_ADD_MUL_ABORT_EN
    abort  = 1'b0;
`endif
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset product", 32'(product), 32'd0);
    check("reset add_b", 32'(add_b), 32'd0);
    check("reset add_a", 32'(add_a), 32'd0);
    rst_n = 1'b1;
    last_prod = '0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_mul(vecs[i].a, vecs[i].b, vecs[i].p);
    end

    // start pulses during RUN and DONE must be ignored
    start = 1'b1; mcand = 8'h0F; mplier = 8'h0F;
    @(negedge clk);
    start  = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 14; c++) begin
      if (done) n_done++;
      if (c == 9) check("ignore-start product", 32'(product), 32'h00E1);
      if (c == 3) begin start = 1'b1; mcand = 8'h02; mplier = 8'h03; end
      if (c == 4) start = 1'b0;
      if (c == 9) start = 1'b1;
      if (c == 10) start = 1'b0;
      @(negedge clk);
    end
    check("ignore-start done count", 32'(n_done), 32'd1);
    check("ignore-start busy", 32'(busy), 32'd0);
    check("ignore-start final", 32'(product), 32'h00E1);
    last_prod = 16'h00E1;
    run_mul(8'h02, 8'h03, 16'h0006);

    // asynchronous reset mid-RUN
    start = 1'b1; mcand = 8'hFF; mplier = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst product", 32'(product), 32'd0);
    #1 rst_n = 1'b1;
    last_prod = '0;
    @(negedge clk);
    check("post rst idle", 32'(busy), 32'd0);
    run_mul(8'h12, 8'h34, 16'h03A8);

    // start held high: done every 10 cycles
    start = 1'b1; mcand = 8'h03; mplier = 8'h05;
    n_done = 0; first_done = 0; last_done = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      check($sformatf("cont done c%0d", c), 32'(done), (c % 10 == 9) ? 32'd1 : 32'd0);
      check($sformatf("cont busy c%0d", c), 32'(busy), (c % 10 != 0) ? 32'd1 : 32'd0);
      if (done) begin
        check($sformatf("cont product c%0d", c), 32'(product), 32'h000F);
        if (n_done == 0) first_done = c;
        else check("cont period", 32'(c - last_done), 32'd10);
        last_done = c;
        n_done++;
      end
    end
    start = 1'b0;
    check("cont first done", 32'(first_done), 32'd9);
    check("cont done count", 32'(n_done), 32'd3);
    last_prod = 16'h000F;
    @(negedge clk);

`ifdef SHIFT_ADD_MUL_ABORT_EN
    run_mul(8'h02, 8'h02, 16'h0004);
    // abort on 4th RUN cycle
    start = 1'b1; mcand = 8'hFF; mplier = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("abort busy c%0d", c), 32'(busy), 32'd1);
      if (c == 4) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("abort no done", 32'(n_done), 32'd0);
    check("abort product", 32'(product), 32'h0004);
    // abort on the last step wins over completion
    start = 1'b1; mcand = 8'hFF; mplier = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (W - 1) @(negedge clk);
    check("abort-last busy", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort-last busy", 32'(busy), 32'd0);
    check("abort-last done", 32'(done), 32'd0);
    check("abort-last product", 32'(product), 32'h0004);
    last_prod = 16'h0004;
    run_mul(8'h03, 8'h05, 16'h000F);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
